// File: rtl/vga_fb_scanout_if.sv
// Framebuffer read port plus DAC/VGA connector pins for the scan-out block.
// The master side is the scan-out engine; the slave side is the RAM/DAC.
interface vga_fb_scanout_if #(
    parameter int DATA_W = 24,
    parameter int ADR_W  = 16
);
    logic [DATA_W-1:0] d;
    logic [ADR_W-1:0]  adr;
    logic [7:0]        VGA_R;
    logic [7:0]        VGA_G;
    logic [7:0]        VGA_B;
    logic              VGA_CLK;
    logic              VGA_BLANK_N;
    logic              VGA_SYNC_N;
    logic              VGA_HS;
    logic              VGA_VS;

    modport master (
        input  d,
        output adr, VGA_R, VGA_G, VGA_B, VGA_CLK, VGA_BLANK_N, VGA_SYNC_N, VGA_HS, VGA_VS
    );

    modport slave (
        output d,
        input  adr, VGA_R, VGA_G, VGA_B, VGA_CLK, VGA_BLANK_N, VGA_SYNC_N, VGA_HS, VGA_VS
    );
endinterface

// File: rtl/vga_fb_scanout.sv
// VGA scan-out: 640x480@60 timing from a 50 MHz clock with a half-rate pixel enable,
// fetching a 2x2-doubled, centred framebuffer image through a 1-cycle-latency RAM port.
module vga_fb_scanout #(
    parameter int DATA_W = 24,
    parameter int ADR_W  = 16,
    parameter int FB_W   = 280,
    parameter int FB_H   = 192,
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic               CLOCK_50,
    input  logic               RESET_N,
    vga_fb_scanout_if.master   fb
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int H_OFF = (H_VIS - 2 * FB_W) / 2;
    localparam int V_OFF = (V_VIS - 2 * FB_H) / 2;

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOT - 1);
    localparam logic [HW-1:0] H_WIN_LO  = HW'(H_OFF);
    localparam logic [HW-1:0] H_WIN_HI  = HW'(H_OFF + 2 * FB_W);
    localparam logic [HW-1:0] H_VIS_C   = HW'(H_VIS);
    localparam logic [HW-1:0] H_SYNC_LO = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] H_SYNC_HI = HW'(H_VIS + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOT - 1);
    localparam logic [VW-1:0] V_WIN_LO  = VW'(V_OFF);
    localparam logic [VW-1:0] V_WIN_HI  = VW'(V_OFF + 2 * FB_H);
    localparam logic [VW-1:0] V_VIS_C   = VW'(V_VIS);
    localparam logic [VW-1:0] V_SYNC_LO = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] V_SYNC_HI = VW'(V_VIS + V_FP + V_SYNC);

    logic              ce_reg, ce_next;
    logic              vga_clk_reg;
    logic [HW-1:0]     h_cnt_reg, h_cnt_next;
    logic [VW-1:0]     v_cnt_reg, v_cnt_next;
    logic [ADR_W-1:0]  adr_reg, adr_next;
    logic [HW-1:0]     h_d_reg;
    logic [VW-1:0]     v_d_reg;
    logic              win_d_reg;
    logic              vld_reg;
    logic [DATA_W-1:0] rgb_reg, rgb_next;
    logic              hs_reg, hs_next;
    logic              vs_reg, vs_next;
    logic              blank_n_reg, blank_n_next;

    logic              in_win;
    logic [HW-1:0]     h_rel;
    logic [VW-1:0]     v_rel;
    logic [ADR_W-1:0]  fb_x, fb_y;

    always_comb begin
        ce_next    = ~ce_reg;
        h_cnt_next = h_cnt_reg + HW'(1);
        v_cnt_next = v_cnt_reg;
        if (h_cnt_reg == H_LAST) begin
            h_cnt_next = '0;
            v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + VW'(1);
        end

        in_win = (h_cnt_reg >= H_WIN_LO) && (h_cnt_reg < H_WIN_HI) &&
                 (v_cnt_reg >= V_WIN_LO) && (v_cnt_reg < V_WIN_HI);
        h_rel  = h_cnt_reg - H_WIN_LO;
        v_rel  = v_cnt_reg - V_WIN_LO;
        // Dropping the LSB of the window-relative position gives the 2x2 pixel doubling.
        fb_x   = ADR_W'(h_rel[HW-1:1]);
        fb_y   = ADR_W'(v_rel[VW-1:1]);
        adr_next = in_win ? (fb_x + fb_y * ADR_W'(FB_W)) : '0;

        // Decode uses the counter values that issued the fetch now arriving on d.
        blank_n_next = (h_d_reg < H_VIS_C) && (v_d_reg < V_VIS_C);
        hs_next      = !((h_d_reg >= H_SYNC_LO) && (h_d_reg < H_SYNC_HI));
        vs_next      = !((v_d_reg >= V_SYNC_LO) && (v_d_reg < V_SYNC_HI));
        rgb_next     = win_d_reg ? fb.d : '0;
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            ce_reg      <= 1'b1;
            vga_clk_reg <= 1'b0;
            h_cnt_reg   <= '0;
            v_cnt_reg   <= '0;
            adr_reg     <= '0;
            h_d_reg     <= '0;
            v_d_reg     <= '0;
            win_d_reg   <= 1'b0;
            vld_reg     <= 1'b0;
            rgb_reg     <= '0;
            hs_reg      <= 1'b1;
            vs_reg      <= 1'b1;
            blank_n_reg <= 1'b0;
        end else begin
            ce_reg      <= ce_next;
            vga_clk_reg <= ce_reg;
            if (ce_reg) begin
                h_cnt_reg <= h_cnt_next;
                v_cnt_reg <= v_cnt_next;
                adr_reg   <= adr_next;
                h_d_reg   <= h_cnt_reg;
                v_d_reg   <= v_cnt_reg;
                win_d_reg <= in_win;
                vld_reg   <= 1'b1;
                // The first pixel period after reset has no fetch in flight yet.
                if (vld_reg) begin
                    rgb_reg     <= rgb_next;
                    hs_reg      <= hs_next;
                    vs_reg      <= vs_next;
                    blank_n_reg <= blank_n_next;
                end
            end
        end
    end

    logic [7:0] chan [3];

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            assign chan[gi] = rgb_reg[DATA_W-1-8*gi -: 8];
        end
    endgenerate

    assign fb.adr         = adr_reg;
    assign fb.VGA_R       = chan[0];
    assign fb.VGA_G       = chan[1];
    assign fb.VGA_B       = chan[2];
    assign fb.VGA_CLK     = vga_clk_reg;
    assign fb.VGA_BLANK_N = blank_n_reg;
    assign fb.VGA_SYNC_N  = 1'b0;
    assign fb.VGA_HS      = hs_reg;
    assign fb.VGA_VS      = vs_reg;
endmodule

// File: tb/tb_vga_fb_scanout.sv
// Scoreboard bench for vga_fb_scanout on a scaled-down raster so several frames fit
// in a short run; expected pixels are derived from the timing/window definitions.
module tb_vga_fb_scanout;
    localparam int DATA_W = 24;
    localparam int ADR_W  = 16;
    localparam int FB_W   = 8;
    localparam int FB_H   = 4;
    localparam int H_VIS  = 24;
    localparam int H_FP   = 4;
    localparam int H_SYNC = 6;
    localparam int H_BP   = 6;
    localparam int V_VIS  = 12;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 2;
    localparam int V_BP   = 4;
    localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int H_OFF  = (H_VIS - 2 * FB_W) / 2;
    localparam int V_OFF  = (V_VIS - 2 * FB_H) / 2;

    typedef struct packed {
        logic        blank_n;
        logic        hs;
        logic        vs;
        logic [23:0] rgb;
    } pix_t;

    localparam pix_t RST_PIX = '{blank_n: 1'b0, hs: 1'b1, vs: 1'b1, rgb: 24'h0};

    logic CLOCK_50 = 1'b0;
    logic RESET_N  = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    int first_blank_rise, hs_fall1, hs_rise1, vs_fall1, vs_rise1, vs_fall2, blank_cnt;

    vga_fb_scanout_if #(.DATA_W(DATA_W), .ADR_W(ADR_W)) vif ();

    vga_fb_scanout #(
        .DATA_W(DATA_W), .ADR_W(ADR_W), .FB_W(FB_W), .FB_H(FB_H),
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .RESET_N  (RESET_N),
        .fb       (vif.master)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Synchronous-read RAM whose word encodes its own address.
    always @(posedge CLOCK_50) vif.d <= {8'hAA, vif.adr};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_win(input int h, input int v);
        return (h >= H_OFF) && (h < H_OFF + 2 * FB_W) && (v >= V_OFF) && (v < V_OFF + 2 * FB_H);
    endfunction

    function automatic logic [15:0] exp_adr(input int h, input int v);
        if (!in_win(h, v)) return 16'd0;
        return 16'((h - H_OFF) / 2 + ((v - V_OFF) / 2) * FB_W);
    endfunction

    function automatic pix_t exp_pix(input int h, input int v);
        pix_t p;
        p.blank_n = (h < H_VIS) && (v < V_VIS);
        p.hs      = !((h >= H_VIS + H_FP) && (h < H_VIS + H_FP + H_SYNC));
        p.vs      = !((v >= V_VIS + V_FP) && (v < V_VIS + V_FP + V_SYNC));
        p.rgb     = in_win(h, v) ? {8'hAA, exp_adr(h, v)} : 24'h0;
        return p;
    endfunction

    function automatic pix_t got_pix();
        return {vif.VGA_BLANK_N, vif.VGA_HS, vif.VGA_VS, vif.VGA_R, vif.VGA_G, vif.VGA_B};
    endfunction

    // Runs n_cyc clocks from reset release (first edge is k=1) checking every pixel.
    task automatic run_scan(input int n_cyc);
        pix_t q[$];
        pix_t p;
        int h = 0, v = 0;
        logic prev_blank = 1'b0, prev_hs = 1'b1, prev_vs = 1'b1;
        first_blank_rise = -1; hs_fall1 = -1; hs_rise1 = -1;
        vs_fall1 = -1; vs_rise1 = -1; vs_fall2 = -1; blank_cnt = 0;
        for (int k = 1; k <= n_cyc; k++) begin
            @(negedge CLOCK_50);
            check_val("vga_clk", 64'(vif.VGA_CLK), 64'(k % 2));
            check_val("sync_n", 64'(vif.VGA_SYNC_N), 64'd0);
            if (k % 2 == 1) begin
                check_val("adr", 64'(vif.adr), 64'(exp_adr(h, v)));
                if (h == H_OFF && v == V_OFF)             check_val("adr_origin", 64'(vif.adr), 64'd0);
                if (h == H_OFF + 2 && v == V_OFF)         check_val("adr_x1", 64'(vif.adr), 64'd1);
                if (h == H_OFF && v == V_OFF + 2)         check_val("adr_y1", 64'(vif.adr), 64'(FB_W));
                if (h == H_OFF + 2*FB_W - 1 && v == V_OFF + 2*FB_H - 1)
                    check_val("adr_last", 64'(vif.adr), 64'(FB_W * FB_H - 1));
                if (h == H_OFF + 2*FB_W && v == V_OFF)    check_val("adr_right", 64'(vif.adr), 64'd0);
                if (h == H_OFF && v == V_OFF - 1)         check_val("adr_above", 64'(vif.adr), 64'd0);
                if (q.size() > 0) begin
                    p = q.pop_front();
                    check_val("pix", 64'(got_pix()), 64'(p));
                end else begin
                    check_val("pix_pre", 64'(got_pix()), 64'(RST_PIX));
                end
                q.push_back(exp_pix(h, v));
                h++;
                if (h == H_TOT) begin
                    h = 0;
                    v = (v == V_TOT - 1) ? 0 : v + 1;
                end
            end
            if (vif.VGA_BLANK_N && !prev_blank && first_blank_rise < 0) first_blank_rise = k;
            if (!vif.VGA_HS && prev_hs && hs_fall1 < 0) hs_fall1 = k;
            if (vif.VGA_HS && !prev_hs && hs_rise1 < 0) hs_rise1 = k;
            if (!vif.VGA_VS && prev_vs) begin
                $display("frame: VS falls at cycle %0d", k);
                if (vs_fall1 < 0) vs_fall1 = k;
                else if (vs_fall2 < 0) vs_fall2 = k;
            end
            if (vif.VGA_VS && !prev_vs && vs_rise1 < 0) vs_rise1 = k;
            if (vs_fall1 >= 0 && vs_fall2 < 0 && vif.VGA_BLANK_N) blank_cnt++;
            prev_blank = vif.VGA_BLANK_N;
            prev_hs    = vif.VGA_HS;
            prev_vs    = vif.VGA_VS;
        end
    endtask

    initial begin
        RESET_N = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        check_val("rst_pix", 64'(got_pix()), 64'(RST_PIX));
        check_val("rst_adr", 64'(vif.adr), 64'd0);
        check_val("rst_vga_clk", 64'(vif.VGA_CLK), 64'd0);
        check_val("rst_sync_n", 64'(vif.VGA_SYNC_N), 64'd0);

        RESET_N = 1'b1;
        run_scan(2 * 2 * H_TOT * V_TOT + 100);
        $display("run1: blank_rise=%0d hs_fall=%0d vs_fall=%0d/%0d", first_blank_rise, hs_fall1, vs_fall1, vs_fall2);
        check_val("first_blank", 64'(first_blank_rise), 64'd3);
        check_val("hs_start", 64'(hs_fall1 - first_blank_rise), 64'(2 * (H_VIS + H_FP)));
        check_val("hs_len", 64'(hs_rise1 - hs_fall1), 64'(2 * H_SYNC));
        check_val("vs_len", 64'(vs_rise1 - vs_fall1), 64'(2 * H_TOT * V_SYNC));
        check_val("frame_period", 64'(vs_fall2 - vs_fall1), 64'(2 * H_TOT * V_TOT));
        check_val("blank_cycles", 64'(blank_cnt), 64'(2 * H_VIS * V_VIS));

        // Restart, then hit reset mid-window at h=10, v=5.
        RESET_N = 1'b0;
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        run_scan(2 * (5 * H_TOT + 10) + 1);
        check_val("pre_rst_blank", 64'(vif.VGA_BLANK_N), 64'd1);
        RESET_N = 1'b0;
        #1;
        check_val("async_rst_pix", 64'(got_pix()), 64'(RST_PIX));
        check_val("async_rst_adr", 64'(vif.adr), 64'd0);
        check_val("async_rst_clk", 64'(vif.VGA_CLK), 64'd0);
        repeat (3) @(negedge CLOCK_50);
        check_val("hold_rst_pix", 64'(got_pix()), 64'(RST_PIX));
        RESET_N = 1'b1;
        run_scan(4 * H_TOT);
        $display("run2: blank_rise=%0d hs_fall=%0d", first_blank_rise, hs_fall1);
        check_val("rst_blank", 64'(first_blank_rise), 64'd3);
        check_val("rst_hs_start", 64'(hs_fall1 - first_blank_rise), 64'(2 * (H_VIS + H_FP)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
